conv_mac_accum: RTL and testbench

- Fixed-point multiply-accumulate stage that directly feeds the leaky ReLU activation stage.
- Accumulates KERNEL_LEN signed Q(DATA_WIDTH-FRAC_WIDTH).FRAC_WIDTH activation×weight products onto a bias.
- Requantizes the wide accumulator back to DATA_WIDTH with round-half-up and saturation.
- Emits one single-cycle valid_out pulse per kernel window; output connects straight to the activation x_in/valid_in.

---
 rtl/conv_mac_accum.sv | 144 ++++++++++++++
 tb/tb_conv_mac_accum.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_accum.sv
// conv_mac_accum: fixed-point multiply-accumulate feeding the leaky ReLU stage.
// Accumulates KERNEL_LEN signed a*w products onto a bias, then requantizes
// to DATA_WIDTH with round-half-up and saturation.
// Optional feature macro: CONV_MAC_SAT_STATS_EN (saturation event counter).
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for start; bias latched into the accumulator on start
// S_ACCUM  | accepting taps (ready_out=1), KERNEL_LEN accepts then leave
// S_OUTPUT | one cycle: round, saturate, register y_out, pulse valid_out
module conv_mac_accum #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_WIDTH = 8,
  parameter int ACC_WIDTH  = 40,
  parameter int KERNEL_LEN = 9
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic signed [DATA_WIDTH-1:0] bias_in,
  input  logic signed [DATA_WIDTH-1:0] a_in,
  input  logic signed [DATA_WIDTH-1:0] w_in,
  input  logic                         valid_in,
  output logic                         ready_out,
  output logic signed [DATA_WIDTH-1:0] y_out,
  output logic                         valid_out,
  output logic                         sat_out,
  output logic                         busy,
  output logic [15:0]                  sat_count
);

  localparam int CNT_W = (KERNEL_LEN > 1) ? $clog2(KERNEL_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(KERNEL_LEN - 1);
  localparam logic signed [ACC_WIDTH-1:0] HALF_LSB = ACC_WIDTH'(1) << (FRAC_WIDTH - 1);
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [DATA_WIDTH-1:0] Y_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] Y_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_OUTPUT} state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic [CNT_W-1:0]             r_count;

  logic                         w_accept;
  logic                         w_last;
  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic signed [ACC_WIDTH-1:0]  w_prod_ext;
  logic signed [ACC_WIDTH-1:0]  w_bias_ext;
  logic signed [ACC_WIDTH-1:0]  w_round;
  logic signed [ACC_WIDTH-1:0]  w_r;
  logic                         w_sat_hi;
  logic                         w_sat_lo;

  assign ready_out  = (r_state == S_ACCUM);
  assign busy       = (r_state != S_IDLE);
  assign w_accept   = ready_out && valid_in;
  assign w_last     = w_accept && (r_count == LAST_TAP);

  assign w_prod     = a_in * w_in;
  assign w_prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){w_prod[2*DATA_WIDTH-1]}}, w_prod};
  // Bias is aligned to the product's 2*FRAC_WIDTH fractional bits.
  assign w_bias_ext = {{(ACC_WIDTH-DATA_WIDTH-FRAC_WIDTH){bias_in[DATA_WIDTH-1]}},
                       bias_in, {FRAC_WIDTH{1'b0}}};
  assign w_round    = r_acc + HALF_LSB;
  assign w_r        = w_round >>> FRAC_WIDTH;
  assign w_sat_hi   = (w_r > ACC_MAX);
  assign w_sat_lo   = (w_r < ACC_MIN);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_ACCUM;
      S_ACCUM:  if (w_last) w_state_nxt = S_OUTPUT;
      S_OUTPUT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Accumulator, tap counter and registered requantized result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_count   <= '0;
      y_out     <= '0;
      valid_out <= 1'b0;
      sat_out   <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc   <= w_bias_ext;
            r_count <= '0;
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            r_acc   <= r_acc + w_prod_ext;
            r_count <= r_count + CNT_W'(1);
          end
        end
        S_OUTPUT: begin
          valid_out <= 1'b1;
          sat_out   <= w_sat_hi || w_sat_lo;
          if (w_sat_hi)      y_out <= Y_MAX;
          else if (w_sat_lo) y_out <= Y_MIN;
          else               y_out <= w_r[DATA_WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

`ifdef CONV_MAC_SAT_STATS_EN
  logic [15:0] r_sat_count;

  // Count saturated results, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_count <= '0;
    end else if ((r_state == S_OUTPUT) && (w_sat_hi || w_sat_lo) &&
                 (r_sat_count != 16'hFFFF)) begin
      r_sat_count <= r_sat_count + 16'd1;
    end
  end

  assign sat_count = r_sat_count;
`else
  assign sat_count = 16'd0;
`endif

endmodule

// File: tb/tb_conv_mac_accum.sv
// Self-checking bench for conv_mac_accum (default parameters).
module tb_conv_mac_accum;
  localparam int DW = 16;
  localparam int FW = 8;
  localparam int K  = 9;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 start = 1'b0;
  logic                 valid_in = 1'b0;
  logic signed [DW-1:0] bias_in = '0;
  logic signed [DW-1:0] a_in = '0;
  logic signed [DW-1:0] w_in = '0;
  logic                 ready_out;
  logic                 valid_out;
  logic                 sat_out;
  logic                 busy;
  logic signed [DW-1:0] y_out;
  logic [15:0]          sat_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int a_q[K];
  int w_q[K];
  int exp_sat_cnt = 0;
  int t_valid = 0;
  int t_first = 0;
  logic [15:0] last_y = '0;

  conv_mac_accum #(.DATA_WIDTH(DW), .FRAC_WIDTH(FW), .ACC_WIDTH(40), .KERNEL_LEN(K)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bias_in(bias_in), .a_in(a_in),
    .w_in(w_in), .valid_in(valid_in), .ready_out(ready_out), .y_out(y_out),
    .valid_out(valid_out), .sat_out(sat_out), .busy(busy), .sat_count(sat_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference: exact real-valued sum scaled by 2^FW, rounded half up, clamped.
  function automatic void model(input int bias, output int y, output bit sat);
    longint s;
    longint r;
    s = longint'(bias) * (longint'(1) << FW);
    for (int i = 0; i < K; i++) s += longint'(a_q[i]) * longint'(w_q[i]);
    r = (s + (longint'(1) << (FW - 1))) >>> FW;
    sat = 1'b0;
    y = int'(r);
    if (r > 32767)  begin y = 32767;  sat = 1'b1; end
    if (r < -32768) begin y = -32768; sat = 1'b1; end
  endfunction

  task automatic set_taps(input int a, input int w);
    for (int i = 0; i < K; i++) begin a_q[i] = a; w_q[i] = w; end
  endtask

  task automatic set_taps_rand(input int range);
    for (int i = 0; i < K; i++) begin
      a_q[i] = int'($urandom_range(2 * range - 1, 0)) - range;
      w_q[i] = int'($urandom_range(2 * range - 1, 0)) - range;
    end
  endtask

  task automatic chk_sat_count(input string tag);
`ifdef CONV_MAC_SAT_STATS_EN
    chk16(tag, sat_count, 16'(exp_sat_cnt));
`else
    chk16(tag, sat_count, 16'd0);
`endif
  endtask

  // gap_pct < 0: valid_in alternates 1/0; otherwise random gap percentage.
  task automatic run_window(input int bias, input int gap_pct, input bit pre_started,
                            input bit start_mid, input bit chain);
    int  acc_n = 0;
    int  iter = 0;
    int  ey;
    bit  es;
    bit  gap;
    model(bias, ey, es);
    if (!pre_started) begin
      @(negedge clk);
      start = 1'b1;
      bias_in = 16'(bias);
    end
    @(negedge clk);
    start = 1'b0;
    bias_in = ~16'(bias);
    chk1("busy_accum", busy, 1'b1);
    while (acc_n < K && iter < 4 * K + 10) begin
      iter++;
      start = start_mid && (iter == 3);
      if (gap_pct < 0) gap = (iter % 2 == 0);
      else             gap = (int'($urandom_range(99, 0)) < gap_pct);
      if (gap) begin
        valid_in = 1'b0;
        a_in = 16'h7fff;
        w_in = 16'h7fff;
      end else begin
        valid_in = 1'b1;
        a_in = 16'(a_q[acc_n]);
        w_in = 16'(w_q[acc_n]);
      end
      chk1("ready_accum", ready_out, 1'b1);
      @(negedge clk);
      if (valid_in) acc_n++;
    end
    if (acc_n < K) chk16("tap_budget", 16'(acc_n), 16'(K));
    valid_in = 1'b0;
    start = 1'b0;
    a_in = '0;
    w_in = '0;
    chk1("ready_output_state", ready_out, 1'b0);
    chk1("valid_not_yet", valid_out, 1'b0);
    chk1("busy_output_state", busy, 1'b1);
    @(negedge clk);
    if (es && exp_sat_cnt != 65535) exp_sat_cnt++;
    chk1("valid_pulse", valid_out, 1'b1);
    chk16("y_out", y_out, 16'(ey));
    chk1("sat_out", sat_out, es);
    chk1("busy_idle", busy, 1'b0);
    chk_sat_count("sat_count");
    t_valid = cyc;
    last_y = 16'(ey);
    if (!chain) begin
      @(negedge clk);
      chk1("valid_single_cycle", valid_out, 1'b0);
      chk16("y_hold", y_out, last_y);
    end
  endtask

  initial begin
    // Reset and reset state.
    #2 rst_n = 1'b0;
    #1;
    chk16("rst_y", y_out, 16'd0);
    chk1("rst_valid", valid_out, 1'b0);
    chk1("rst_sat", sat_out, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_ready", ready_out, 1'b0);
    chk16("rst_sat_count", sat_count, 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Unity taps: 9 x (1.0 * 1.0) = 9.0.
    set_taps(256, 256);
    run_window(0, 0, 1'b0, 1'b0, 1'b0);

    // Rounding: +0.5 LSB rounds up, -0.5 LSB rounds up to 0.
    set_taps(0, 0); a_q[0] = 1; w_q[0] = 128;
    run_window(0, 0, 1'b0, 1'b0, 1'b0);
    chk16("round_pos", y_out, 16'd1);
    a_q[0] = -1;
    run_window(0, 0, 1'b0, 1'b0, 1'b0);
    chk16("round_neg", y_out, 16'd0);

    // Bias only with alternating valid_in.
    set_taps(0, 0);
    run_window(512, -1, 1'b0, 1'b0, 1'b0);
    chk16("bias_only", y_out, 16'd512);

    // start during ACCUM must not restart or relatch bias.
    set_taps_rand(300);
    run_window(-77, 20, 1'b0, 1'b1, 1'b0);

    // Saturation both directions.
    set_taps(32767, 32767);
    run_window(0, 0, 1'b0, 1'b0, 1'b0);
    chk16("sat_max", y_out, 16'h7fff);
    set_taps(-32768, 32767);
    run_window(0, 0, 1'b0, 1'b0, 1'b0);
    chk16("sat_min", y_out, 16'h8000);
    chk1("sat_min_flag", sat_out, 1'b1);

    // Mid-window reset after 4 taps.
    set_taps(1000, 1000);
    @(negedge clk); start = 1'b1; bias_in = 16'sd100;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid_in = 1'b1; a_in = 16'sd1000; w_in = 16'sd1000;
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    exp_sat_cnt = 0;
    chk16("midrst_y", y_out, 16'd0);
    chk1("midrst_valid", valid_out, 1'b0);
    chk1("midrst_sat", sat_out, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    chk16("midrst_sat_count", sat_count, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // valid_in in IDLE is ignored.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("idle_ready", ready_out, 1'b0);
      chk1("idle_busy", busy, 1'b0);
      chk1("idle_no_valid", valid_out, 1'b0);
    end
    valid_in = 1'b0;
    set_taps_rand(200);
    run_window(33, 0, 1'b0, 1'b0, 1'b0);

    // Back-to-back windows: second start in the valid_out cycle.
    set_taps_rand(500);
    run_window(-300, 0, 1'b0, 1'b0, 1'b1);
    t_first = t_valid;
    set_taps_rand(500);
    start = 1'b1;
    bias_in = 16'sd250;
    run_window(250, 0, 1'b1, 1'b0, 1'b0);
    chk16("b2b_period", 16'(t_valid - t_first), 16'(K + 2));

    // Randomized windows: moderate range, then full range (saturation likely).
    for (int n = 0; n < 8; n++) begin
      set_taps_rand(2048);
      run_window(int'($urandom_range(4095, 0)) - 2048, 30, 1'b0, 1'b0, 1'b0);
    end
    for (int n = 0; n < 4; n++) begin
      set_taps_rand(32768);
      run_window(int'($urandom_range(65535, 0)) - 32768, 10, 1'b0, 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
